// File: rtl/debounce.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state
// qualifier that accepts a new level only after STABLE_CYCLES identical samples.
module debounce #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_clean,
  output logic o_busy,
  output logic o_glitch
);

  localparam logic [1:0] LOW      = 2'd0;
  localparam logic [1:0] CHK_HIGH = 2'd1;
  localparam logic [1:0] HIGH     = 2'd2;
  localparam logic [1:0] CHK_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clean_nxt;
  logic             glitch_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_async;
      s2 <= s1;
    end
  end

  // A sample opposite to the candidate level aborts qualification with no partial credit.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    clean_nxt  = o_clean;
    glitch_nxt = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          state_nxt = CHK_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      CHK_HIGH: begin
        if (!s2) begin
          state_nxt  = LOW;
          cnt_nxt    = '0;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          clean_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nxt = CHK_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      CHK_LOW: begin
        if (s2) begin
          state_nxt  = HIGH;
          cnt_nxt    = '0;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          clean_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
        clean_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= LOW;
      cnt      <= '0;
      o_clean  <= 1'b0;
      o_glitch <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      o_clean  <= clean_nxt;
      o_glitch <= glitch_nxt;
    end
  end

  assign o_busy = (state == CHK_HIGH) || (state == CHK_LOW);

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce: directed scenarios plus randomized bursts,
// all compared against a sample-run reference model.
module tb_debounce;

  localparam int STABLE = 4;
  localparam int CNT_W  = 3;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_async;
  logic o_clean;
  logic o_busy;
  logic o_glitch;

  int checkCount = 0;
  int errorCount = 0;

  // Reference: accepted level plus length of the current run of samples disagreeing with it.
  bit m_s1, m_s2, m_clean, m_glitch;
  int m_run;

  debounce #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_async),
    .o_clean (o_clean),
    .o_busy  (o_busy),
    .o_glitch(o_glitch)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_s1 = 0; m_s2 = 0; m_clean = 0; m_glitch = 0; m_run = 0;
  endtask

  task automatic modelEdge(input bit sample);
    m_glitch = 0;
    if (m_s2 != m_clean) begin
      m_run++;
      if (m_run == STABLE) begin
        m_clean = !m_clean;
        m_run   = 0;
      end
    end else begin
      if (m_run > 0) m_glitch = 1;
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = sample;
  endtask

  task automatic stepCycle();
    @(posedge i_clk);
    if (i_rst_n) modelEdge(i_async);
    #1;
    checkOutput("model_clean", o_clean, m_clean);
    checkOutput("model_busy", o_busy, (m_run > 0));
    checkOutput("model_glitch", o_glitch, m_glitch);
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    i_async = level;
    repeat (cycles) stepCycle();
  endtask

  task automatic pulseReset();
    #3;
    i_rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_clean", o_clean, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_glitch", o_glitch, 0);
    stepCycle();
    stepCycle();
    i_rst_n = 1'b1;
  endtask

  initial begin
    int glitches;
    int riseEdge;
    int cleanChanges;
    logic prevClean;

    i_async = 1'b0;
    i_rst_n = 1'b0;
    modelReset();
    #2;
    checkOutput("reset_clean", o_clean, 0);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_glitch", o_glitch, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Clean press: busy after edges 3..5, clean after edge 6.
    i_async = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      stepCycle();
      checkOutput("press_busy", o_busy, (e >= 3 && e <= 5));
      checkOutput("press_clean", o_clean, (e == 6));
      checkOutput("press_glitch", o_glitch, 0);
    end
    applyStimulus(1'b1, 3);

    // Release from HIGH.
    i_async = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      stepCycle();
      checkOutput("release_clean", o_clean, (e < 6));
    end
    applyStimulus(1'b0, 3);

    // Bounce on press: high 2, low 1, then held high.
    glitches = 0;
    riseEdge = 0;
    for (int e = 1; e <= 11; e++) begin
      i_async = (e == 3) ? 1'b0 : 1'b1;
      stepCycle();
      if (o_glitch) glitches++;
      if (o_clean && riseEdge == 0) riseEdge = e;
    end
    checkOutput("bounce_glitches", glitches, 1);
    checkOutput("bounce_rise_edge", riseEdge, 9);

    // Three-cycle low glitch while HIGH.
    glitches = 0;
    cleanChanges = 0;
    for (int e = 1; e <= 10; e++) begin
      i_async = (e <= 3) ? 1'b0 : 1'b1;
      stepCycle();
      if (o_glitch) glitches++;
      if (!o_clean) cleanChanges++;
    end
    checkOutput("high_glitch_pulses", glitches, 1);
    checkOutput("high_glitch_clean_drops", cleanChanges, 0);

    // Toggle every 2 cycles for 40 cycles, then settle high.
    glitches = 0;
    cleanChanges = 0;
    prevClean = o_clean;
    for (int e = 0; e < 44; e++) begin
      i_async = (e >= 40) ? 1'b1 : (((e / 2) % 2) == 1);
      stepCycle();
      if (o_glitch) glitches++;
      if (o_clean !== prevClean) cleanChanges++;
    end
    checkOutput("toggle_glitch_pulses", glitches, 10);
    checkOutput("toggle_clean_changes", cleanChanges, 0);

    // Reset while qualifying a press with cnt=2.
    applyStimulus(1'b0, 8);
    i_async = 1'b1;
    repeat (4) stepCycle();
    checkOutput("midcheck_busy", o_busy, 1);
    pulseReset();
    for (int e = 1; e <= 6; e++) begin
      stepCycle();
      checkOutput("post_reset_clean", o_clean, (e == 6));
    end

    // Randomized bursts with occasional resets.
    for (int b = 0; b < 70; b++) begin
      if ($urandom_range(0, 19) == 0) pulseReset();
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
